// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared datapath widths and result/load encodings for the CPU core
package cpu_defs_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int COUNT_WIDTH = 32;
  localparam logic [1:0] RESULT_ALU = 2'd0;
  localparam logic [1:0] RESULT_LOAD = 2'd1;
  localparam logic [1:0] RESULT_LINK = 2'd2;
  localparam logic [2:0] LOAD_LW = 3'd0;
  localparam logic [2:0] LOAD_LB = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: little-endian lane select, sign/zero extension and misalignment detect
module load_formatter
  import cpu_defs_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] raw_word,
  input  logic [2:0]            load_type,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] load_word,
  output logic                  misaligned
);
  logic [7:0] lane_byte;
  logic [15:0] lane_half;
  logic is_half;
  logic is_word;
  assign lane_byte = raw_word[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
  assign is_half = load_type == LOAD_LH || load_type == LOAD_LHU;
  // Unknown encodings fall through to word behaviour, including the alignment rule
  assign is_word = !is_half && load_type != LOAD_LB && load_type != LOAD_LBU;
  always_comb begin
    load_word = load_type == LOAD_LB  ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte} :
                load_type == LOAD_LBU ? {{(DATA_WIDTH-8){1'b0}}, lane_byte} :
                load_type == LOAD_LH  ? {{(DATA_WIDTH-16){lane_half[15]}}, lane_half} :
                load_type == LOAD_LHU ? {{(DATA_WIDTH-16){1'b0}}, lane_half} :
                raw_word;
    misaligned = (is_half && offset[0]) || (is_word && offset != 2'b00);
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register driving the register-file write port, with retire/align counters
module mem_wb_stage
  import cpu_defs_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mem_valid,
  input  logic                   mem_rd_write_enable,
  input  logic [ADDR_WIDTH-1:0]  mem_rd_address,
  input  logic [1:0]             mem_result_sel,
  input  logic [DATA_WIDTH-1:0]  mem_alu_result,
  input  logic [DATA_WIDTH-1:0]  mem_load_data,
  input  logic [2:0]             mem_load_type,
  input  logic [DATA_WIDTH-1:0]  mem_link_pc,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic                   rd_write_enable,
  output logic [ADDR_WIDTH-1:0]  rd_address,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   wb_valid,
  output logic                   wb_align_error,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output logic [COUNT_WIDTH-1:0] align_error_count
);
  logic [DATA_WIDTH-1:0] load_word;
  logic fmt_misaligned;
  logic misaligned;
  logic [DATA_WIDTH-1:0] result;
  load_formatter u_fmt (
    .raw_word   (mem_load_data),
    .load_type  (mem_load_type),
    .offset     (mem_alu_result[1:0]),
    .load_word  (load_word),
    .misaligned (fmt_misaligned)
  );
  assign misaligned = mem_result_sel == RESULT_LOAD && fmt_misaligned;
  assign result = mem_result_sel == RESULT_LOAD ? load_word :
                  mem_result_sel == RESULT_LINK ? mem_link_pc : mem_alu_result;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_write_enable <= 1'b0;
      rd_address <= '0;
      rd_data <= '0;
      wb_valid <= 1'b0;
      wb_align_error <= 1'b0;
      retired_count <= '0;
      align_error_count <= '0;
    end else if (flush_in || (!stall_in && !mem_valid)) begin
      rd_write_enable <= 1'b0;
      rd_address <= '0;
      rd_data <= '0;
      wb_valid <= 1'b0;
      wb_align_error <= 1'b0;
    end else if (stall_in) begin
      // Hold the write target but drop strobes so the write is not repeated
      rd_write_enable <= 1'b0;
      wb_valid <= 1'b0;
      wb_align_error <= 1'b0;
    end else begin
      rd_write_enable <= mem_rd_write_enable && mem_rd_address != '0 && !misaligned;
      rd_address <= mem_rd_address;
      rd_data <= result;
      wb_valid <= 1'b1;
      wb_align_error <= misaligned;
      retired_count <= retired_count + COUNT_WIDTH'(1);
      align_error_count <= align_error_count + COUNT_WIDTH'(misaligned);
    end
  end
endmodule
